// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions used by the read, write, refresh and init engines:
// command encodings ({cs_n,ras_n,cas_n,we_n}), the one-hot read-engine state
// encoding and small elaboration-time sizing helpers.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_BST   = 4'b0110;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    // Read engine states, one-hot so that each state decodes from a single bit.
    typedef enum logic [7:0] {
        ST_IDLE = 8'b0000_0001,
        ST_ACT  = 8'b0000_0010,
        ST_TRCD = 8'b0000_0100,
        ST_RD   = 8'b0000_1000,
        ST_DATA = 8'b0001_0000,
        ST_PRE  = 8'b0010_0000,
        ST_TRP  = 8'b0100_0000,
        ST_END  = 8'b1000_0000
    } rd_state_e;

    // Largest of three timing parameters, used to size a shared wait counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 32'sd1);
        if (w < 32'sd1) w = 32'sd1;
        return w;
    endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// Read-data capture for the SDRAM burst reader.
// sd_dq passes through STAGES registers (1 = single capture, 2 = IOB register
// plus retime). The burst strobe from the command FSM is delayed by
// CAS_LAT+STAGES cycles so rd_valid lines up with the captured word.
// rd_data only updates on valid words and otherwise holds its last value.
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CAS_LAT = 3,
    parameter int STAGES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              burst,
    input  logic [DATA_W-1:0] sd_dq,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = CAS_LAT + STAGES;

    logic [DEPTH-1:0]  vld_pipe_r;
    logic [DATA_W-1:0] dq_src_s;

    // Valid delay line: a word slot issued by the FSM emerges CAS_LAT+STAGES later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_r <= {DEPTH{1'b0}};
        end else begin
            vld_pipe_r <= {vld_pipe_r[DEPTH-2:0], burst};
        end
    end

    generate
        if (STAGES > 1) begin : g_iob
            logic [DATA_W-1:0] dq_iob_r;

            // Free-running IOB capture of the pad data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dq_iob_r <= {DATA_W{1'b0}};
                end else begin
                    dq_iob_r <= sd_dq;
                end
            end

            assign dq_src_s = dq_iob_r;
        end else begin : g_direct
            assign dq_src_s = sd_dq;
        end
    endgenerate

    // Final data register: loads only when the aligned strobe marks a burst word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= {DATA_W{1'b0}};
        end else if (vld_pipe_r[DEPTH-2]) begin
            rd_data <= dq_src_s;
        end else begin
            rd_data <= rd_data;
        end
    end

    assign rd_valid = vld_pipe_r[DEPTH-1];

endmodule

// File: rtl/sdram_burst_reader.sv
// SDRAM full-page burst read engine.
// One request issues ACTIVE, READ, BURST TERMINATE, PRECHARGE(all) and returns
// exactly rd_len words (clamped to one page) on rd_data/rd_valid. A zero-length
// request is acknowledged and completed without touching the SDRAM.
// All command/handshake outputs are registered: the FSM decodes its current
// state and the result appears at the pins on the following cycle.
// Build option: define SDRAM_RD_DQ_REG_EN to add a second sd_dq capture stage;
// the data window then moves one cycle later, command timing is unchanged.
module sdram_burst_reader
    import sdram_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int BANK_W  = 2,
    parameter int ROW_W   = 13,
    parameter int COL_W   = 9,
    parameter int CAS_LAT = 3,
    parameter int T_RCD   = 2,
    parameter int T_RP    = 2,
    parameter int LEN_W   = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_done,
    input  logic                          rd_req,
    input  logic [LEN_W-1:0]              rd_len,
    input  logic [BANK_W+ROW_W+COL_W-1:0] rd_addr,
    output logic                          rd_ack,
    output logic                          rd_busy,
    output logic                          rd_end,
    output logic [3:0]                    sd_cmd,
    output logic [BANK_W-1:0]             sd_ba,
    output logic [ROW_W-1:0]              sd_addr,
    input  logic [DATA_W-1:0]             sd_dq,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data
);

`ifdef SDRAM_RD_DQ_REG_EN
    localparam int DQ_STAGES = 2;
`else
    localparam int DQ_STAGES = 1;
`endif

    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int WAIT_W = cnt_width(max3(T_RCD, T_RP, CAS_LAT));

    localparam logic [LEN_W-1:0] PAGE_WORDS = LEN_W'(1) << COL_W;
    // PRECHARGE with A10 high closes every bank.
    localparam logic [ROW_W-1:0] PRE_ADDR   = ROW_W'(1) << 4'd10;

    rd_state_e          state_r, state_s;
    logic [LEN_W-1:0]   len_r, len_s, len_clamp_s;
    logic [WAIT_W-1:0]  wait_r, wait_s;
    logic [BANK_W-1:0]  bank_r;
    logic [ROW_W-1:0]   row_r;
    logic [COL_W-1:0]   col_r;
    logic [3:0]         cmd_s;
    logic [BANK_W-1:0]  ba_s;
    logic [ROW_W-1:0]   addr_s;
    logic               ack_s, end_s, busy_s, accept_s, burst_s;

    // Oversized requests read one full page; the column wraps inside the row.
    assign len_clamp_s = (rd_len > PAGE_WORDS) ? PAGE_WORDS : rd_len;

    // One word slot per DATA cycle; the capture block delays it to the data pins.
    assign burst_s = (state_r == ST_DATA);

    // Next-state and next-output decode for the command sequencer.
    always_comb begin
        state_s  = state_r;
        len_s    = len_r;
        wait_s   = wait_r;
        cmd_s    = CMD_NOP;
        ba_s     = sd_ba;
        addr_s   = sd_addr;
        ack_s    = 1'b0;
        end_s    = 1'b0;
        accept_s = 1'b0;
        busy_s   = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (rd_req && init_done) begin
                    accept_s = 1'b1;
                    ack_s    = 1'b1;
                    busy_s   = 1'b1;
                    len_s    = len_clamp_s;
                    if (rd_len == LEN_W'(0)) begin
                        state_s = ST_END;
                    end else begin
                        state_s = ST_ACT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACT: begin
                cmd_s  = CMD_ACT;
                ba_s   = bank_r;
                addr_s = row_r;
                if (T_RCD == 1) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_TRCD;
                    wait_s  = WAIT_W'(T_RCD - 2);
                end
            end
            ST_TRCD: begin
                if (wait_r == WAIT_W'(0)) begin
                    state_s = ST_RD;
                end else begin
                    wait_s = wait_r - WAIT_W'(1);
                end
            end
            ST_RD: begin
                cmd_s   = CMD_READ;
                ba_s    = bank_r;
                addr_s  = {{(ROW_W-COL_W){1'b0}}, col_r};
                state_s = ST_DATA;
            end
            ST_DATA: begin
                // Remaining-word counter saturates at zero.
                if (len_r != LEN_W'(0)) begin
                    len_s = len_r - LEN_W'(1);
                end else begin
                    len_s = len_r;
                end
                if (len_r <= LEN_W'(1)) begin
                    cmd_s   = CMD_BST;
                    state_s = ST_PRE;
                    wait_s  = WAIT_W'(CAS_LAT - 1);
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PRE: begin
                // Hold off PRECHARGE until the terminated burst has drained.
                if (wait_r == WAIT_W'(0)) begin
                    cmd_s  = CMD_PRE;
                    addr_s = PRE_ADDR;
                    if (T_RP == 1) begin
                        state_s = ST_END;
                    end else begin
                        state_s = ST_TRP;
                        wait_s  = WAIT_W'(T_RP - 2);
                    end
                end else begin
                    wait_s = wait_r - WAIT_W'(1);
                end
            end
            ST_TRP: begin
                if (wait_r == WAIT_W'(0)) begin
                    state_s = ST_END;
                end else begin
                    wait_s = wait_r - WAIT_W'(1);
                end
            end
            ST_END: begin
                end_s   = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered command/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            len_r   <= {LEN_W{1'b0}};
            wait_r  <= {WAIT_W{1'b0}};
            sd_cmd  <= CMD_NOP;
            sd_ba   <= {BANK_W{1'b1}};
            sd_addr <= {ROW_W{1'b1}};
            rd_ack  <= 1'b0;
            rd_end  <= 1'b0;
            rd_busy <= 1'b0;
        end else begin
            state_r <= state_s;
            len_r   <= len_s;
            wait_r  <= wait_s;
            sd_cmd  <= cmd_s;
            sd_ba   <= ba_s;
            sd_addr <= addr_s;
            rd_ack  <= ack_s;
            rd_end  <= end_s;
            rd_busy <= busy_s;
        end
    end

    // Request address is latched on accept and held for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r <= {BANK_W{1'b0}};
            row_r  <= {ROW_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
        end else if (accept_s) begin
            bank_r <= rd_addr[ADDR_W-1 -: BANK_W];
            row_r  <= rd_addr[COL_W +: ROW_W];
            col_r  <= rd_addr[COL_W-1:0];
        end else begin
            bank_r <= bank_r;
            row_r  <= row_r;
            col_r  <= col_r;
        end
    end

    sdram_rd_capture #(
        .DATA_W  (DATA_W),
        .CAS_LAT (CAS_LAT),
        .STAGES  (DQ_STAGES)
    ) u_capture (
        .clk      (clk),
        .rst_n    (rst_n),
        .burst    (burst_s),
        .sd_dq    (sd_dq),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Directed testbench for sdram_burst_reader with a small SDRAM read model.
// The model returns word {bank, row[4:0], col} for every column, so the bench
// can compute each expected word from the request address alone.
module tb_sdram_burst_reader;

    localparam int CAS_LAT = 3;
    localparam int T_RCD   = 2;
    localparam int T_RP    = 2;
    localparam int LEN_W   = 10;
`ifdef SDRAM_RD_DQ_REG_EN
    localparam int DQX = 1;
`else
    localparam int DQX = 0;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             init_done = 1'b0;
    logic             rd_req    = 1'b0;
    logic [LEN_W-1:0] rd_len    = 10'd0;
    logic [23:0]      rd_addr   = 24'd0;
    logic             rd_ack, rd_busy, rd_end, rd_valid;
    logic [3:0]       sd_cmd;
    logic [1:0]       sd_ba;
    logic [12:0]      sd_addr;
    logic [15:0]      sd_dq = 16'h0000;
    logic [15:0]      rd_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    sdram_burst_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .rd_req    (rd_req),
        .rd_len    (rd_len),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_busy   (rd_busy),
        .rd_end    (rd_end),
        .sd_cmd    (sd_cmd),
        .sd_ba     (sd_ba),
        .sd_addr   (sd_addr),
        .sd_dq     (sd_dq),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] word_of(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c);
        return {b, r[4:0], c};
    endfunction

    // SDRAM read model: row opened by ACT, data CAS_LAT after READ, stops CAS_LAT after BST.
    logic [12:0] m_row [4] = '{default: 13'h0};
    int          m_rd_cyc  = -1000;
    int          m_bst_cyc = -1000;
    logic [1:0]  m_rd_bank = 2'd0;
    logic [8:0]  m_col     = 9'd0;

    always @(negedge clk) begin
        if (sd_cmd == 4'b0011) m_row[sd_ba] <= sd_addr;
        if (sd_cmd == 4'b0101) begin
            m_rd_cyc  <= cyc;
            m_rd_bank <= sd_ba;
            m_col     <= sd_addr[8:0];
        end
        if (sd_cmd == 4'b0110) m_bst_cyc <= cyc;
        if ((cyc >= m_rd_cyc + CAS_LAT) && !((m_bst_cyc > m_rd_cyc) && (cyc >= m_bst_cyc + CAS_LAT)))
            sd_dq <= word_of(m_rd_bank, m_row[m_rd_bank], m_col + 9'(cyc - m_rd_cyc - CAS_LAT));
        else
            sd_dq <= 16'hBAD0;
    end

    // Observations of one transaction.
    int          ack_c, act_c, rdc_c, bst_c, pre_c, end_c;
    int          v_first, v_last, v_cnt, v_err, cmd_cnt, busy_gap;
    logic [1:0]  act_ba, rdc_ba;
    logic [12:0] act_addr, rdc_addr, pre_addr;
    logic [15:0] last_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic collect(input logic [23:0] addr, input bit hold, input bit drop_init, input int budget);
        logic [15:0] expw;
        ack_c = -1; act_c = -1; rdc_c = -1; bst_c = -1; pre_c = -1; end_c = -1;
        v_first = -1; v_last = -1; v_cnt = 0; v_err = 0; cmd_cnt = 0; busy_gap = 0;
        act_ba = 2'd0; rdc_ba = 2'd0; act_addr = 13'd0; rdc_addr = 13'd0; pre_addr = 13'd0;
        for (int i = 0; i < budget && end_c < 0; i++) begin
            @(negedge clk);
            if (rd_ack === 1'b1 && ack_c < 0) begin
                ack_c = cyc;
                if (!hold) rd_req = 1'b0;
                if (drop_init) init_done = 1'b0;
            end
            if (ack_c >= 0 && rd_busy !== 1'b1) busy_gap++;
            case (sd_cmd)
                4'b0011: begin act_c = cyc; act_ba = sd_ba; act_addr = sd_addr; cmd_cnt++; end
                4'b0101: begin rdc_c = cyc; rdc_ba = sd_ba; rdc_addr = sd_addr; cmd_cnt++; end
                4'b0110: begin bst_c = cyc; cmd_cnt++; end
                4'b0010: begin pre_c = cyc; pre_addr = sd_addr; cmd_cnt++; end
                4'b0111: begin end
                default: cmd_cnt++;
            endcase
            if (rd_valid === 1'b1) begin
                expw = word_of(addr[23:22], addr[21:9], addr[8:0] + 9'(v_cnt));
                if (v_first < 0) v_first = cyc;
                v_last = cyc;
                if (rd_data !== expw) v_err++;
                v_cnt++;
                last_word = expw;
            end
            if (rd_end === 1'b1) end_c = cyc;
        end
    endtask

    task automatic check_txn(input string tag, input int len, input logic [23:0] addr);
        chk({tag, "_ack"},     32'(ack_c >= 0), 32'd1);
        chk({tag, "_act_ba"},  32'(act_ba), 32'(addr[23:22]));
        chk({tag, "_act_row"}, 32'(act_addr), 32'(addr[21:9]));
        chk({tag, "_rd_at"},   32'(rdc_c - act_c), 32'(T_RCD));
        chk({tag, "_rd_ba"},   32'(rdc_ba), 32'(addr[23:22]));
        chk({tag, "_rd_col"},  32'(rdc_addr), {23'd0, addr[8:0]});
        chk({tag, "_bst_at"},  32'(bst_c - rdc_c), 32'(len));
        chk({tag, "_pre_at"},  32'(pre_c - rdc_c), 32'(len + CAS_LAT));
        chk({tag, "_pre_a"},   32'(pre_addr), 32'h0000_0400);
        chk({tag, "_end_at"},  32'(end_c - pre_c), 32'(T_RP));
        chk({tag, "_v_first"}, 32'(v_first - rdc_c), 32'(CAS_LAT + 1 + DQX));
        chk({tag, "_v_cnt"},   32'(v_cnt), 32'(len));
        chk({tag, "_v_span"},  32'(v_last - v_first), 32'(len - 1));
        chk({tag, "_v_data"},  32'(v_err), 32'd0);
        chk({tag, "_cmds"},    32'(cmd_cnt), 32'd4);
        chk({tag, "_busy"},    32'(busy_gap), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd"},   32'(sd_cmd), 32'h7);
        chk({tag, "_ba"},    32'(sd_ba), 32'h3);
        chk({tag, "_addr"},  32'(sd_addr), 32'h1FFF);
        chk({tag, "_data"},  32'(rd_data), 32'h0);
        chk({tag, "_strb"},  {28'd0, rd_valid, rd_ack, rd_end, rd_busy}, 32'h0);
    endtask

    initial begin
        int n_ack, n_cmd, e1;
        bit saw_valid;

        // 1: reset, then release with rd_req=1 but init_done=0.
        rd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        n_ack = 0; n_cmd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_ack !== 1'b0) n_ack++;
            if (sd_cmd !== 4'b0111) n_cmd++;
        end
        chk("noinit_ack", 32'(n_ack), 32'd0);
        chk("noinit_cmd", 32'(n_cmd), 32'd0);

        // 2: rd_len=10 at bank 1, row 0x55, col 4.
        rd_len = 10'd10; rd_addr = {2'd1, 13'h0055, 9'h004};
        init_done = 1'b1;
        collect(rd_addr, 1'b0, 1'b0, 100);
        check_txn("t2", 10, {2'd1, 13'h0055, 9'h004});
        chk("t2_bst_abs", 32'(bst_c), 32'(act_c + 12));
        chk("t2_pre_abs", 32'(pre_c), 32'(act_c + 15));
        chk("t2_vfirst_abs", 32'(v_first), 32'(act_c + 6 + DQX));
        chk("t2_vlast_abs", 32'(v_last), 32'(act_c + 15 + DQX));
        chk("t2_end_abs", 32'(end_c), 32'(act_c + 17));
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("t2_idle_valid", 32'(rd_valid), 32'd0);
        chk("t2_hold_data", 32'(rd_data), 32'(word_of(2'd1, 13'h0055, 9'h00D)));
        chk("t2_idle_busy", 32'(rd_busy), 32'd0);

        // 3: single word, full page, and an oversized request clamped to a page.
        rd_len = 10'd1; rd_addr = {2'd2, 13'h1ABC, 9'h000}; rd_req = 1'b1;
        collect(rd_addr, 1'b0, 1'b0, 100);
        check_txn("t3a", 1, {2'd2, 13'h1ABC, 9'h000});
        rd_len = 10'd512; rd_req = 1'b1;
        collect(rd_addr, 1'b0, 1'b0, 700);
        check_txn("t3b", 512, {2'd2, 13'h1ABC, 9'h000});
        rd_len = 10'd600; rd_addr = {2'd3, 13'h0F0F, 9'h100}; rd_req = 1'b1;
        collect(rd_addr, 1'b0, 1'b0, 700);
        check_txn("t3c", 512, {2'd3, 13'h0F0F, 9'h100});

        // 4: column wrap inside the row; init_done drops mid-transaction.
        rd_len = 10'd4; rd_addr = {2'd0, 13'h0003, 9'h1FE}; rd_req = 1'b1;
        collect(rd_addr, 1'b0, 1'b1, 100);
        check_txn("t4", 4, {2'd0, 13'h0003, 9'h1FE});
        chk("t4_last_word", 32'(last_word), 32'h0000_0601);
        init_done = 1'b1;

        // 5: rd_req held across a transaction, then a zero-length request.
        rd_len = 10'd5; rd_addr = {2'd1, 13'h0011, 9'h020}; rd_req = 1'b1;
        collect(rd_addr, 1'b1, 1'b0, 100);
        check_txn("t5a", 5, {2'd1, 13'h0011, 9'h020});
        e1 = end_c;
        collect(rd_addr, 1'b0, 1'b0, 100);
        chk("t5_reack", 32'(ack_c), 32'(e1 + 1));
        check_txn("t5b", 5, {2'd1, 13'h0011, 9'h020});
        rd_len = 10'd0; rd_req = 1'b1;
        collect(rd_addr, 1'b0, 1'b0, 20);
        chk("t5z_ack", 32'(ack_c >= 0), 32'd1);
        chk("t5z_end", 32'(end_c - ack_c), 32'd1);
        chk("t5z_cmds", 32'(cmd_cnt), 32'd0);
        chk("t5z_valid", 32'(v_cnt), 32'd0);

        // 6: asynchronous reset during the data phase, then recovery.
        @(negedge clk);
        rd_len = 10'd20; rd_addr = {2'd2, 13'h0007, 9'h010}; rd_req = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 60 && !saw_valid; i++) begin
            @(negedge clk);
            if (rd_ack === 1'b1) rd_req = 1'b0;
            if (rd_valid === 1'b1) saw_valid = 1'b1;
        end
        chk("t6_in_data", 32'(saw_valid), 32'd1);
        rd_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        n_cmd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sd_cmd !== 4'b0111 || rd_busy !== 1'b0) n_cmd++;
        end
        chk("t6_quiet", 32'(n_cmd), 32'd0);
        rd_len = 10'd3; rd_addr = {2'd3, 13'h0002, 9'h0F0}; rd_req = 1'b1;
        collect(rd_addr, 1'b0, 1'b0, 100);
        check_txn("t6r", 3, {2'd3, 13'h0002, 9'h0F0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
